// File: rtl/fetch_pkg.sv
// Shared widths, constants and enums for the instruction-fetch block.
package fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int PC_STEP = 2;

  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_HOLD  = 2'd0,
    NPC_INC   = 2'd1,
    NPC_REDIR = 2'd2
  } npc_sel_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: hold, sequential step, or halfword-aligned redirect.
module fetch_next_pc #(
  parameter int ADDR_W = fetch_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  fetch_pkg::npc_sel_e i_sel,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic [ADDR_W-1:0] o_next_pc
);
  import fetch_pkg::*;

  always_comb begin
    o_next_pc = i_pc;
    case (i_sel)
      NPC_INC:   o_next_pc = i_pc + ADDR_W'(PC_STEP);
      NPC_REDIR: o_next_pc = {i_redirect_addr[ADDR_W-1:1], 1'b0};
      default:   o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, drives the combinational IM port and
// registers each returned word with its address into a valid-tagged fetch register.
module fetch_unit #(
  parameter int                  ADDR_W    = fetch_pkg::ADDR_W,
  parameter int                  INSTR_W   = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC  = 8'h00,
  parameter logic [INSTR_W-1:0]  HALT_WORD = fetch_pkg::HALT_WORD
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_instr,
  input  logic [ADDR_W-1:0]  im_addr_echo,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  output logic               halted,
  output logic               addr_err,
  output logic [7:0]         fetch_count
);
  import fetch_pkg::*;

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  npc_sel_e           w_npc_sel;
  logic               w_capture;
  logic               w_bubble;
  logic               w_is_halt;
  logic [ADDR_W-1:0]  w_next_pc;

  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_out;
  logic               r_valid;
  logic               r_halted;
  logic               r_addr_err;
  logic [7:0]         r_count;

  assign w_is_halt = (im_instr == HALT_WORD);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Priority inside S_RUN: redirect beats stall beats normal fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_npc_sel   = NPC_HOLD;
    w_capture   = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (redirect) begin
          w_npc_sel = NPC_REDIR;
          w_bubble  = 1'b1;
        end else if (!stall) begin
          w_capture = 1'b1;
          if (w_is_halt) w_state_nxt = S_HALT;
          else           w_npc_sel   = NPC_INC;
        end
      end
      S_HALT: w_bubble = 1'b1;
      default: w_state_nxt = S_RUN;
    endcase
  end

  fetch_next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .i_pc           (r_pc),
    .i_sel          (w_npc_sel),
    .i_redirect_addr(redirect_addr),
    .o_next_pc      (w_next_pc)
  );

  // Fetch register stage: capture on fetch edges, drop valid on bubble/halt edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_pc_out   <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_addr_err <= 1'b0;
      r_count    <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_capture) begin
        r_instr  <= im_instr;
        r_pc_out <= r_pc;
        r_valid  <= 1'b1;
        if (r_count != 8'hFF)      r_count    <= r_count + 8'd1;
        if (im_addr_echo != r_pc)  r_addr_err <= 1'b1;
        if (w_is_halt)             r_halted   <= 1'b1;
      end else if (w_bubble) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign im_addr     = r_pc;
  assign instr_out   = r_instr;
  assign pc_out      = r_pc_out;
  assign instr_valid = r_valid;
  assign halted      = r_halted;
  assign addr_err    = r_addr_err;
  assign fetch_count = r_count;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch initiator that drives the instruction memory (IM) and delivers fetched words to decode. It owns the program counter, issues one halfword-aligned address per cycle, and registers the returned 16-bit instruction with its address into a valid-tagged fetch register. It supports decode stalls, branch/jump redirects and a sticky halt on a program-end word. The IM is a purely combinational read port; this block is its only requester.

## Interface
- ADDR_W, 8, PC and IM address width
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC value after reset
- HALT_WORD, 16'h0000, fetched word that ends the program
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- im_addr  out  ADDR_W  address to IM, always equal to the pc register
- im_instr  in  INSTR_W  IM read data for im_addr, same cycle
- im_addr_echo  in  ADDR_W  IM address echo, compared against im_addr
- stall  in  1  decode cannot accept; hold fetch register and PC
- redirect  in  1  load PC from redirect_addr this edge
- redirect_addr  in  ADDR_W  branch/jump target; bit 0 ignored
- instr_out  out  INSTR_W  registered instruction
- pc_out  out  ADDR_W  address instr_out was fetched from
- instr_valid  out  1  instr_out/pc_out hold a live instruction
- halted  out  1  HALT_WORD captured; fetch stopped
- addr_err  out  1  sticky; im_addr_echo != im_addr seen on a fetch edge
- fetch_count  out  8  instructions captured since reset, saturates at 8'hFF

## Operation
- Two states: S_RUN, S_HALT. Reset enters S_RUN.
- Per-edge priority: rst > S_HALT hold > redirect > stall > normal fetch.
- Normal fetch (S_RUN, no stall, no redirect): instr_out<=im_instr, pc_out<=pc, instr_valid<=1, fetch_count+1 (saturating), pc<=pc+2 mod 256 (8'hFE wraps to 8'h00).
- If the captured word == HALT_WORD, it is still presented with instr_valid=1. In the same edge: pc holds (no increment), state->S_HALT, halted<=1.
- S_HALT: pc and instr_out/pc_out freeze; instr_valid<=0 on the first S_HALT edge and stays 0. stall and redirect are ignored. Only rst exits.
- redirect (S_RUN): pc<={redirect_addr[7:1],1'b0}, instr_valid<=0 (one-cycle bubble), instr_out/pc_out hold, fetch_count unchanged. redirect overrides a simultaneous stall.
- stall (S_RUN, no redirect): pc, instr_out, pc_out, instr_valid and fetch_count all hold.
- addr_err: set when im_addr_echo != im_addr on any capturing edge. Cleared only by rst.
- pc bit 0 is always 0, so the IM is never addressed at 8'hFF.

## Timing
- Reset values: pc=RESET_PC, im_addr=RESET_PC, instr_out=16'h0000, pc_out=8'h00, instr_valid=0, halted=0, addr_err=0, fetch_count=0.
- Latency is 1 cycle: the address driven in cycle N is captured at the end of N and valid in N+1.
- Throughput is 1 instruction/cycle with no stall.
- Redirect at edge N: the target is on im_addr in N+1, and its instruction is valid in N+2.
- Reset asserted mid-operation (including S_HALT or during a stall) takes effect at the next edge. Output values on that edge are the reset values.
- Stall released at edge N: fetch resumes at the held pc in that cycle. No instruction is dropped or duplicated.

## Structure
- Shared package fetch_pkg: ADDR_W, INSTR_W, PC_STEP=2, HALT_WORD default, state enum {S_RUN, S_HALT}.
- One sub-module, fetch_next_pc: combinational next-PC select (hold / +2 / redirect aligned). Everything else is in fetch_unit.

## Test plan
- IM model with 0x00=F120, 0x02=F121, 0x04=93FF, 0x06=0000. Release reset -> instr_out F120@00, F121@02, 93FF@04, 0000@06 on consecutive cycles; then halted=1, instr_valid=0 next cycle, fetch_count=4.
- stall for 3 cycles after F121@02 is captured -> outputs and im_addr=04 frozen; release -> 93FF@04 next cycle, with no duplicate of F121.
- redirect to 8'h21 while pc=04 -> im_addr=20 next cycle, one bubble (instr_valid=0), then mem[20]@20 valid.
- Sequential fetch from pc=FE with a nonzero word -> pc_out=FE, next im_addr=00.
- rst asserted in S_HALT, and separately during a stall -> all outputs at reset values next cycle; fetch restarts at 00.
- IM model echo forced to 8'h10 when im_addr=08 -> addr_err=1 and stays 1 until rst.
